// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: parity modes, FSM encoding, FIFO entry width.
// Latency: none (package only).
// Backpressure: none (package only).
package uart_pkg;

   // Parity selection values for the PARITY parameter
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // Receiver FSM encoding
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START   = 3'd1;
   localparam logic [2:0] ST_DATA    = 3'd2;
   localparam logic [2:0] ST_PARITY  = 3'd3;
   localparam logic [2:0] ST_STOP    = 3'd4;
   localparam logic [2:0] ST_WAIT_HI = 3'd5;

   // A FIFO entry holds {frame_err, parity_err, data}
   function automatic int entry_width(input int data_bits);
      return data_bits + 2;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fall-through FIFO with full/empty/count status.
// Latency: a write is visible at the head one clock after the write edge.
// Backpressure: writes while full are dropped unless a pop happens in the same cycle; pops while empty are ignored.
module uart_sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic                     i_Clock,
   input  logic                     i_Rst_n,
   input  logic                     i_Wr_En,
   input  logic [WIDTH-1:0]         i_Wr_Data,
   input  logic                     i_Rd_En,
   output logic [WIDTH-1:0]         o_Rd_Data,
   output logic                     o_Full,
   output logic                     o_Empty,
   output logic [$clog2(DEPTH):0]   o_Count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             rd_ok;
   logic             wr_ok;

   assign o_Full  = (count == CNT_FULL);
   assign o_Empty = (count == '0);
   assign o_Count = count;
   assign rd_ok   = i_Rd_En && !o_Empty;
   // When full, a simultaneous pop frees the slot the write lands in
   assign wr_ok   = i_Wr_En && (!o_Full || rd_ok);
   // Head is forced to zero when empty so stale storage never leaks out
   assign o_Rd_Data = o_Empty ? '0 : mem[rd_ptr];

   // Storage array, no reset needed: contents are only visible when counted
   always_ff @(posedge i_Clock) begin
      if (wr_ok) mem[wr_ptr] <= i_Wr_Data;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing, glitch/parity/framing/break detection, feeding a FWFT FIFO.
// Latency: 2-cycle input sync; entry appears one clock after the mid-point of the last stop bit.
// Backpressure: none on the line; frames arriving into a full FIFO are dropped and flagged in o_Overrun.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = PAR_NONE,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          i_Clock,
   input  logic                          i_Rst_n,
   input  logic                          i_Rx_Serial,
   input  logic                          i_Rd_En,
   input  logic                          i_Clr_Err,
   output logic                          o_Rx_Valid,
   output logic [DATA_BITS-1:0]          o_Rx_Byte,
   output logic                          o_Parity_Err,
   output logic                          o_Frame_Err,
   output logic                          o_Overrun,
   output logic                          o_Break,
   output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);
   localparam int EW = entry_width(DATA_BITS);

   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_MID   = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   logic                 rx_meta;
   logic                 rx_s;
   logic [2:0]           state;
   logic [CW-1:0]        clk_cnt;
   logic [IW-1:0]        idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 par_bit;
   logic                 par_err;
   logic                 stop_lo;
   logic                 stop_hi;
   logic                 brk_q;
   logic                 overrun_q;

   logic                 bit_done;
   logic                 last_stop;
   logic                 frame_err;
   logic                 is_break;
   logic                 push;
   logic                 drop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [EW-1:0]        head;

   // Frame-end decode; the current stop sample is folded in combinationally
   assign bit_done  = (clk_cnt == CNT_LAST);
   assign last_stop = (state == ST_STOP) && bit_done && (stop_idx == STOP_LAST);
   assign frame_err = stop_lo | ~rx_s;
   assign is_break  = (shift == '0) && ((PARITY == PAR_NONE) || !par_bit) && !stop_hi && !rx_s;
   assign push      = last_stop && !is_break;
   // Full always implies non-empty, so any read request frees a slot
   assign drop      = push && fifo_full && !i_Rd_En;

   // Two-flop synchroniser, preset to the idle-high line level
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_Rx_Serial;
         rx_s    <= rx_meta;
      end
   end

   // Receive FSM: mid-bit sampling driven by the bit-clock counter
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state    <= ST_IDLE;
         clk_cnt  <= '0;
         idx      <= '0;
         stop_idx <= 1'b0;
         shift    <= '0;
         par_bit  <= 1'b0;
         par_err  <= 1'b0;
         stop_lo  <= 1'b0;
         stop_hi  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  clk_cnt  <= '0;
                  idx      <= '0;
                  stop_idx <= 1'b0;
                  par_bit  <= 1'b0;
                  par_err  <= 1'b0;
                  stop_lo  <= 1'b0;
                  stop_hi  <= 1'b0;
                  state    <= ST_START;
               end
            end
            ST_START: begin
               if (clk_cnt == CNT_MID) begin
                  clk_cnt <= '0;
                  state   <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  clk_cnt    <= '0;
                  shift[idx] <= rx_s;
                  if (idx == IDX_LAST) begin
                     state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            ST_PARITY: begin
               if (bit_done) begin
                  clk_cnt <= '0;
                  par_bit <= rx_s;
                  par_err <= (^shift) ^ rx_s ^ (PARITY == PAR_ODD);
                  state   <= ST_STOP;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            ST_STOP: begin
               if (bit_done) begin
                  clk_cnt <= '0;
                  stop_lo <= stop_lo | ~rx_s;
                  stop_hi <= stop_hi | rx_s;
                  if (stop_idx == STOP_LAST) begin
                     // Leave at mid-bit so a following start edge is caught early
                     state <= is_break ? ST_WAIT_HI : ST_IDLE;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            ST_WAIT_HI: begin
               if (rx_s) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Break pulse and sticky overrun; a new overrun beats a simultaneous clear
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         brk_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         brk_q <= last_stop && is_break;
         if (drop)           overrun_q <= 1'b1;
         else if (i_Clr_Err) overrun_q <= 1'b0;
      end
   end

   uart_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_Clock   (i_Clock),
      .i_Rst_n   (i_Rst_n),
      .i_Wr_En   (push),
      .i_Wr_Data ({frame_err, par_err, shift}),
      .i_Rd_En   (i_Rd_En),
      .o_Rd_Data (head),
      .o_Full    (fifo_full),
      .o_Empty   (fifo_empty),
      .o_Count   (o_Fifo_Count)
   );

   assign o_Rx_Valid   = !fifo_empty;
   assign o_Rx_Byte    = head[DATA_BITS-1:0];
   assign o_Parity_Err = head[DATA_BITS];
   assign o_Frame_Err  = head[DATA_BITS+1];
   assign o_Overrun    = overrun_q;
   assign o_Break      = brk_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo across three framing configurations.
// Latency: checks sampled on falling edges after each frame completes.
// Backpressure: bench pops explicitly through i_Rd_En.
module tb_uart_rx_fifo;

   localparam int CPB = 87;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_line [3];
   logic rd_en   [3];
   logic clr     [3];

   int n_checks = 0;
   int n_fail   = 0;

   // Instance a: 8N1, depth 4
   logic       a_vld, a_pe, a_fe, a_ovr, a_brk;
   logic [7:0] a_byte;
   logic [2:0] a_cnt;
   // Instance b: 8E1, depth 8
   logic       b_vld, b_pe, b_fe, b_ovr, b_brk;
   logic [7:0] b_byte;
   logic [3:0] b_cnt;
   // Instance c: 5N2, depth 8
   logic       c_vld, c_pe, c_fe, c_ovr, c_brk;
   logic [4:0] c_byte;
   logic [3:0] c_cnt;

   always #50 clk = ~clk;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
      .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_line[0]), .i_Rd_En(rd_en[0]), .i_Clr_Err(clr[0]),
      .o_Rx_Valid(a_vld), .o_Rx_Byte(a_byte), .o_Parity_Err(a_pe), .o_Frame_Err(a_fe),
      .o_Overrun(a_ovr), .o_Break(a_brk), .o_Fifo_Count(a_cnt));

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(8)) u_b (
      .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_line[1]), .i_Rd_En(rd_en[1]), .i_Clr_Err(clr[1]),
      .o_Rx_Valid(b_vld), .o_Rx_Byte(b_byte), .o_Parity_Err(b_pe), .o_Frame_Err(b_fe),
      .o_Overrun(b_ovr), .o_Break(b_brk), .o_Fifo_Count(b_cnt));

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(8)) u_c (
      .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_line[2]), .i_Rd_En(rd_en[2]), .i_Clr_Err(clr[2]),
      .o_Rx_Valid(c_vld), .o_Rx_Byte(c_byte), .o_Parity_Err(c_pe), .o_Frame_Err(c_fe),
      .o_Overrun(c_ovr), .o_Break(c_brk), .o_Fifo_Count(c_cnt));

   task automatic bit_wait(input int n);
      repeat (n * CPB) @(negedge clk);
   endtask

   // par < 0 means no parity bit; otherwise par[0] is the parity bit driven
   task automatic send_frame(input int inst, input logic [8:0] data, input int nbits,
                             input int par, input int nstop, input logic stop_val);
      rx_line[inst] = 1'b0;
      bit_wait(1);
      for (int i = 0; i < nbits; i++) begin
         rx_line[inst] = data[i];
         bit_wait(1);
      end
      if (par >= 0) begin
         rx_line[inst] = par[0];
         bit_wait(1);
      end
      for (int i = 0; i < nstop; i++) begin
         rx_line[inst] = stop_val;
         bit_wait(1);
      end
      rx_line[inst] = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic pop(input int inst);
      rd_en[inst] = 1'b1;
      @(negedge clk);
      rd_en[inst] = 1'b0;
   endtask

   // Count break pulses on instance a over n cycles
   task automatic watch_break(input int n, inout int pulses);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (a_brk === 1'b1) pulses++;
      end
   endtask

   task automatic test_reset();
      repeat (5) @(negedge clk);
      n_checks++; if (a_vld !== 1'b0 || a_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_a_fifo: vld=%b cnt=%0d want 0/0", a_vld, a_cnt); end
      n_checks++; if (a_ovr !== 1'b0 || a_brk !== 1'b0 || a_byte !== 8'h00) begin n_fail++; $display("FAIL rst_a_flags: ovr=%b brk=%b byte=%h want 0", a_ovr, a_brk, a_byte); end
      n_checks++; if (b_cnt !== 4'd0 || c_cnt !== 4'd0 || c_vld !== 1'b0) begin n_fail++; $display("FAIL rst_bc: bcnt=%0d ccnt=%0d cvld=%b want 0", b_cnt, c_cnt, c_vld); end
      rst_n = 1'b1;
      bit_wait(1);
   endtask

   task automatic test_back_to_back();
      send_frame(0, 9'h03F, 8, -1, 1, 1'b1);
      send_frame(0, 9'h0A5, 8, -1, 1, 1'b1);
      n_checks++; if (a_cnt !== 3'd2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", a_cnt); end
      n_checks++; if (a_byte !== 8'h3F || a_pe !== 1'b0 || a_fe !== 1'b0) begin n_fail++; $display("FAIL b2b_first: byte=%h pe=%b fe=%b want 3f/0/0", a_byte, a_pe, a_fe); end
      pop(0);
      n_checks++; if (a_byte !== 8'hA5 || a_vld !== 1'b1 || a_cnt !== 3'd1) begin n_fail++; $display("FAIL b2b_second: byte=%h vld=%b cnt=%0d want a5/1/1", a_byte, a_vld, a_cnt); end
      pop(0);
      n_checks++; if (a_vld !== 1'b0 || a_cnt !== 3'd0 || a_byte !== 8'h00) begin n_fail++; $display("FAIL b2b_empty: vld=%b cnt=%0d byte=%h want 0", a_vld, a_cnt, a_byte); end
      pop(0);
      n_checks++; if (a_cnt !== 3'd0) begin n_fail++; $display("FAIL pop_empty: cnt=%0d want 0", a_cnt); end
   endtask

   task automatic test_parity();
      send_frame(1, 9'h03F, 8, 0, 1, 1'b1);
      send_frame(1, 9'h03F, 8, 1, 1, 1'b1);
      n_checks++; if (b_cnt !== 4'd2) begin n_fail++; $display("FAIL par_count: got %0d want 2", b_cnt); end
      n_checks++; if (b_byte !== 8'h3F || b_pe !== 1'b0 || b_fe !== 1'b0) begin n_fail++; $display("FAIL par_good: byte=%h pe=%b fe=%b want 3f/0/0", b_byte, b_pe, b_fe); end
      pop(1);
      n_checks++; if (b_byte !== 8'h3F || b_pe !== 1'b1 || b_fe !== 1'b0) begin n_fail++; $display("FAIL par_bad: byte=%h pe=%b fe=%b want 3f/1/0", b_byte, b_pe, b_fe); end
      pop(1);
   endtask

   task automatic test_frame_break();
      int pulses;
      send_frame(0, 9'h055, 8, -1, 1, 1'b0);
      bit_wait(1);
      n_checks++; if (a_cnt !== 3'd1 || a_byte !== 8'h55 || a_fe !== 1'b1 || a_pe !== 1'b0) begin n_fail++; $display("FAIL frame_err: cnt=%0d byte=%h fe=%b pe=%b want 1/55/1/0", a_cnt, a_byte, a_fe, a_pe); end
      pop(0);
      pulses = 0;
      rx_line[0] = 1'b0;
      watch_break(20 * CPB, pulses);
      rx_line[0] = 1'b1;
      watch_break(2 * CPB, pulses);
      n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL break_pulses: got %0d want 1", pulses); end
      n_checks++; if (a_vld !== 1'b0 || a_cnt !== 3'd0) begin n_fail++; $display("FAIL break_no_entry: vld=%b cnt=%0d want 0/0", a_vld, a_cnt); end
   endtask

   task automatic test_glitch();
      int pulses;
      pulses = 0;
      rx_line[0] = 1'b0;
      watch_break(20, pulses);
      rx_line[0] = 1'b1;
      watch_break(2 * CPB, pulses);
      n_checks++; if (a_vld !== 1'b0 || a_fe !== 1'b0 || a_pe !== 1'b0 || pulses != 0) begin n_fail++; $display("FAIL glitch: vld=%b fe=%b pe=%b brk=%0d want all 0", a_vld, a_fe, a_pe, pulses); end
      send_frame(0, 9'h0C3, 8, -1, 1, 1'b1);
      n_checks++; if (a_cnt !== 3'd1 || a_byte !== 8'hC3 || a_fe !== 1'b0 || a_pe !== 1'b0) begin n_fail++; $display("FAIL after_glitch: cnt=%0d byte=%h fe=%b pe=%b want 1/c3/0/0", a_cnt, a_byte, a_fe, a_pe); end
      pop(0);
   endtask

   task automatic test_overrun();
      logic [7:0] vals [5];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
      for (int i = 0; i < 5; i++) send_frame(0, {1'b0, vals[i]}, 8, -1, 1, 1'b1);
      n_checks++; if (a_cnt !== 3'd4 || a_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_full: cnt=%0d ovr=%b want 4/1", a_cnt, a_ovr); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (a_byte !== vals[i] || a_vld !== 1'b1) begin n_fail++; $display("FAIL ovr_order%0d: byte=%h vld=%b want %h/1", i, a_byte, a_vld, vals[i]); end
         pop(0);
      end
      n_checks++; if (a_cnt !== 3'd0 || a_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: cnt=%0d ovr=%b want 0/1", a_cnt, a_ovr); end
      clr[0] = 1'b1;
      @(negedge clk);
      clr[0] = 1'b0;
      n_checks++; if (a_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: ovr=%b want 0", a_ovr); end
   endtask

   task automatic test_5n2_reset();
      send_frame(2, 9'h01B, 5, -1, 2, 1'b1);
      n_checks++; if (c_cnt !== 4'd1 || c_byte !== 5'h1B || c_fe !== 1'b0) begin n_fail++; $display("FAIL 5n2_rx: cnt=%0d byte=%h fe=%b want 1/1b/0", c_cnt, c_byte, c_fe); end
      // Start a frame and reset part way through the data bits
      rx_line[2] = 1'b0;
      bit_wait(1);
      rx_line[2] = 1'b1;
      bit_wait(2);
      rst_n = 1'b0;
      rx_line[2] = 1'b1;
      repeat (10) @(negedge clk);
      n_checks++; if (c_vld !== 1'b0 || c_cnt !== 4'd0 || c_byte !== 5'h00 || c_fe !== 1'b0 || c_ovr !== 1'b0 || c_brk !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: vld=%b cnt=%0d byte=%h fe=%b want all 0", c_vld, c_cnt, c_byte, c_fe); end
      rst_n = 1'b1;
      bit_wait(2);
      send_frame(2, 9'h00E, 5, -1, 2, 1'b1);
      n_checks++; if (c_cnt !== 4'd1 || c_byte !== 5'h0E || c_fe !== 1'b0 || c_pe !== 1'b0) begin n_fail++; $display("FAIL midrst_next: cnt=%0d byte=%h fe=%b pe=%b want 1/0e/0/0", c_cnt, c_byte, c_fe, c_pe); end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rx_line[i] = 1'b1;
         rd_en[i]   = 1'b0;
         clr[i]     = 1'b0;
      end
      test_reset();
      test_back_to_back();
      test_parity();
      test_frame_break();
      test_glitch();
      test_overrun();
      test_5n2_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
